herald_cmd_engine: RTL
======================

HERALD_CMD_ENGINE -- requirements
Module: herald_cmd_engine

Interface
REQ-001 SHALL have parameter OPW, default 32: operand width in bits; multiple of 8, range 8..64.
REQ-002 SHALL have parameter MAX_OPS, default 2: maximum operands per command; range 1..3.
REQ-003 SHALL have parameter RESW, default 64: maximum result width in bits; one of 16, 32, 64.
REQ-004 SHALL have parameter TIMEOUT, default 1023: maximum cycles spent waiting for a response; range 1..65535.
REQ-005 SHALL have the following ports, with reset rst_n asynchronous and active-low, and clock clk:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- din  in  8  host write byte
- wr_strobe  in  1  host write strobe; acts on rising edge
- rd_strobe  in  1  host read strobe; acts on rising edge
- abort  in  1  level abort request
- dout  out  8  registered host read byte
- busy  out  1  high in states LOAD, ISSUE and WAIT
- cmd_valid  out  1  command issue valid
- cmd_ready  in  1  downstream accepts command
- cmd_op  out  8  latched command byte
- op_bus  out  MAX_OPS*OPW  operands; operand k occupies bits [k*OPW +: OPW]
- rsp_valid  in  1  downstream result valid
- rsp_ready  out  1  engine accepts result
- rsp_data  in  RESW  result word

Function
REQ-006 SHALL detect edges as strobe high with the registered previous strobe value low; the action SHALL take effect at that same clock edge.
REQ-007 SHALL decode the command byte as follows:
- bits [7:6]: operand count N.
- bits [5:4]: result-size code R, where R=0 gives 0 bytes, 1 gives 2 bytes, 2 gives 4 bytes, 3 gives 8 bytes.
- bits [3:0]: opaque, passed through on cmd_op.
REQ-008 SHALL implement states IDLE, LOAD, ISSUE, WAIT, DRAIN.
REQ-009 IDLE: a wr edge SHALL latch din into cmd_op, clear op_bus and the byte counter, then transition:
- illegal command (N>MAX_OPS or result bytes>RESW/8) -> err_code=1, stay IDLE.
- N=0 -> ISSUE.
- otherwise -> LOAD.
REQ-010 LOAD: each wr edge SHALL write din to the next op_bus byte, LSB first, operand 0 first; after the N*OPW/8-th byte the engine SHALL enter ISSUE.
REQ-011 ISSUE: cmd_valid SHALL be 1 and cmd_op/op_bus SHALL be stable; when cmd_valid and cmd_ready are both high, the engine SHALL enter WAIT on the next cycle.
REQ-012 WAIT: rsp_ready SHALL be 1; when rsp_valid and rsp_ready are both high, the engine SHALL latch rsp_data, then go to DRAIN if the result has bytes, otherwise to IDLE.
REQ-013 WAIT timeout: the cycle counter SHALL reset on entry to WAIT; if TIMEOUT cycles elapse without a response, the engine SHALL set err_code=2 and enter IDLE.
REQ-014 DRAIN: each rd edge SHALL load dout with the next result byte, LSB first; after the final byte dout SHALL hold that byte and the engine SHALL enter IDLE.
REQ-015 IDLE status read: an rd edge SHALL load dout with {6'b0, err_code} and clear err_code.
REQ-016 Simultaneous wr and rd edges in IDLE: the wr edge SHALL win and the rd edge SHALL be dropped.
REQ-017 In IDLE and LOAD, rd edges other than the status read of REQ-015 SHALL be ignored; in ISSUE, WAIT and DRAIN, wr edges SHALL be ignored.
REQ-018 abort high in LOAD or DRAIN SHALL force IDLE next cycle and set err_code=3; abort SHALL be ignored in ISSUE and WAIT, where the timeout of REQ-013 provides recovery.
REQ-019 cmd_valid SHALL be 1 only in ISSUE and rsp_ready SHALL be 1 only in WAIT, so no cycle has both high.
REQ-020 err_code SHALL be sticky: a later error SHALL overwrite it and only a status read SHALL clear it.

Reset
REQ-021 rst_n low SHALL immediately force the following, regardless of state (including mid-LOAD or mid-WAIT):
- state IDLE;
- dout=0, busy=0, cmd_valid=0, rsp_ready=0, cmd_op=0, op_bus=0;
- err_code=0, counters=0, previous-strobe registers=0.

Verification (defaults; downstream stub)
REQ-022 cmd 0x6A, bytes 78 56 34 12 -> ISSUE with op_bus[31:0]=0x12345678, cmd_op=0x6A; stub returns 0x00000000DEADBEEF -> four reads give EF BE AD DE, then IDLE with busy=0.
REQ-023 cmd 0xB0, A bytes 01 00 00 00, B bytes 02 00 00 00 -> op_bus=0x0000000200000001; stub returns 0x1122334455667788 -> eight reads give 88 77 66 55 44 33 22 11.
REQ-024 cmd 0xC0 -> stays IDLE, busy never asserts, cmd_valid never asserts; status read gives 0x01, next status read gives 0x00.
REQ-025 TIMEOUT=16, cmd 0x05, stub accepts command but never responds -> exactly 16 cycles after entering WAIT the engine is IDLE; status read gives 0x02.
REQ-026 abort pulse after 2 operand bytes of 0x6A -> IDLE, status 0x03; a following 0x05 command completes normally with cmd_ready held 1 and rsp_valid returned 3 cycles later.
REQ-027 rst_n asserted while in WAIT -> all outputs 0 asynchronously; after release, a status read gives 0x00.

Source files
------------

// File: rtl/herald_cmd_engine.sv
// Byte-serial command engine: a host loads a command byte and operands,
// the engine issues them downstream, waits for a result and lets the host drain it.
module herald_cmd_engine #(
  parameter int OPW     = 32,
  parameter int MAX_OPS = 2,
  parameter int RESW    = 64,
  parameter int TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               din,
  input  logic                     wr_strobe,
  input  logic                     rd_strobe,
  input  logic                     abort,
  output logic [7:0]               dout,
  output logic                     busy,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [7:0]               cmd_op,
  output logic [MAX_OPS*OPW-1:0]   op_bus,
  input  logic                     rsp_valid,
  output logic                     rsp_ready,
  input  logic [RESW-1:0]          rsp_data
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam int OPB = OPW / 8;
  localparam int OBW = MAX_OPS * OPW;
  localparam int RBY = RESW / 8;

  logic [2:0]      state_q,    state_d;
  logic [7:0]      cmd_op_q,   cmd_op_d;
  logic [OBW-1:0]  op_bus_q,   op_bus_d;
  logic [RESW-1:0] res_q,      res_d;
  logic [4:0]      byte_cnt_q, byte_cnt_d;
  logic [15:0]     tmo_cnt_q,  tmo_cnt_d;
  logic [1:0]      err_q,      err_d;
  logic [7:0]      dout_q,     dout_d;
  logic            wr_prev_q,  wr_prev_d;
  logic            rd_prev_q,  rd_prev_d;

  logic            wr_edge_s;
  logic            rd_edge_s;
  logic            illegal_s;

  // Result-size code to byte count.
  function automatic logic [3:0] res_bytes(input logic [1:0] code);
    logic [3:0] nbytes;
    case (code)
      2'd0:    nbytes = 4'd0;
      2'd1:    nbytes = 4'd2;
      2'd2:    nbytes = 4'd4;
      default: nbytes = 4'd8;
    endcase
    return nbytes;
  endfunction

  // Total operand bytes for an operand count.
  function automatic logic [4:0] op_bytes(input logic [1:0] n);
    return 5'(n) * 5'(OPB);
  endfunction

  assign wr_edge_s = wr_strobe & ~wr_prev_q;
  assign rd_edge_s = rd_strobe & ~rd_prev_q;
  assign illegal_s = (din[7:6] > 2'(MAX_OPS)) || (res_bytes(din[5:4]) > 4'(RBY));

  // Next-state and datapath updates for the command sequencer.
  always_comb begin
    state_d    = state_q;
    cmd_op_d   = cmd_op_q;
    op_bus_d   = op_bus_q;
    res_d      = res_q;
    byte_cnt_d = byte_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    err_d      = err_q;
    dout_d     = dout_q;
    wr_prev_d  = wr_strobe;
    rd_prev_d  = rd_strobe;

    case (state_q)
      S_IDLE: begin
        // A write edge takes priority; a coincident read edge is dropped.
        if (wr_edge_s) begin
          cmd_op_d   = din;
          op_bus_d   = '0;
          byte_cnt_d = 5'd0;
          if (illegal_s) begin
            err_d = 2'd1;
          end else if (din[7:6] == 2'd0) begin
            state_d = S_ISSUE;
          end else begin
            state_d = S_LOAD;
          end
        end else if (rd_edge_s) begin
          dout_d = {6'b000000, err_q};
          err_d  = 2'd0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
          err_d   = 2'd3;
        end else if (wr_edge_s) begin
          for (int k = 0; k < OBW / 8; k++) begin
            op_bus_d[k*8 +: 8] = (byte_cnt_q == 5'(k)) ? din : op_bus_d[k*8 +: 8];
          end
          if (byte_cnt_q == op_bytes(cmd_op_q[7:6]) - 5'd1) begin
            state_d    = S_ISSUE;
            byte_cnt_d = 5'd0;
          end else begin
            byte_cnt_d = byte_cnt_q + 5'd1;
          end
        end else begin
          state_d = S_LOAD;
        end
      end

      S_ISSUE: begin
        if (cmd_ready) begin
          state_d   = S_WAIT;
          tmo_cnt_d = 16'd0;
        end else begin
          state_d = S_ISSUE;
        end
      end

      S_WAIT: begin
        if (rsp_valid) begin
          res_d      = rsp_data;
          byte_cnt_d = 5'd0;
          state_d    = (res_bytes(cmd_op_q[5:4]) == 4'd0) ? S_IDLE : S_DRAIN;
        end else if (tmo_cnt_q == 16'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
          err_d   = 2'd2;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end

      S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
          err_d   = 2'd3;
        end else if (rd_edge_s) begin
          for (int k = 0; k < RBY; k++) begin
            dout_d = (byte_cnt_q == 5'(k)) ? res_q[k*8 +: 8] : dout_d;
          end
          if (byte_cnt_q == {1'b0, res_bytes(cmd_op_q[5:4])} - 5'd1) begin
            state_d    = S_IDLE;
            byte_cnt_d = 5'd0;
          end else begin
            byte_cnt_d = byte_cnt_q + 5'd1;
          end
        end else begin
          state_d = S_DRAIN;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cmd_op_q   <= 8'h00;
      op_bus_q   <= '0;
      res_q      <= '0;
      byte_cnt_q <= 5'd0;
      tmo_cnt_q  <= 16'd0;
      err_q      <= 2'd0;
      dout_q     <= 8'h00;
      wr_prev_q  <= 1'b0;
      rd_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_op_q   <= cmd_op_d;
      op_bus_q   <= op_bus_d;
      res_q      <= res_d;
      byte_cnt_q <= byte_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      err_q      <= err_d;
      dout_q     <= dout_d;
      wr_prev_q  <= wr_prev_d;
      rd_prev_q  <= rd_prev_d;
    end
  end

  // Handshake and status outputs decode the state register directly.
  assign busy      = (state_q == S_LOAD) || (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign cmd_valid = (state_q == S_ISSUE);
  assign rsp_ready = (state_q == S_WAIT);
  assign cmd_op    = cmd_op_q;
  assign op_bus    = op_bus_q;
  assign dout      = dout_q;

endmodule
